stack_sequencer: RTL

- Multi-cycle sequencer for the stack-transfer instructions CALL, RET, INT and RTI, plus hardware interrupt entry.
- Sits beside the decode stage. It captures a qualifying opcode, stalls the front end, and issues a series of 16-bit push/pop beats to the memory stage over a req/ack handshake.
- When the series completes, it loads the PC and, where applicable, the flags.
- The single-cycle control decode treats these opcodes as NOPs; this block provides their behaviour.

---
 rtl/stack_sequencer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/stack_sequencer.sv
// stack_sequencer: multi-cycle sequencer for CALL, RET, INT, RTI and hardware interrupt entry.
// Captures a qualifying decode-stage opcode, stalls the front end, issues 16-bit push/pop
// beats to the memory stage over a req/ack handshake, then loads PC (and flags for RTI).
// The PC is moved as two DATA_W halves, so PC_W is expected to equal 2*DATA_W.
//
// Ports:
//   clk, rst                    clock (rising edge), asynchronous active-high reset
//   op_valid, opcode            decode-stage opcode and its valid
//   pc_cur, pc_ret, target      current PC, return address, CALL destination
//   flags_in                    current {C,N,Z}
//   int_req                     level-sensitive hardware interrupt request
//   mem_ack, mem_rdata          beat completion and pop data from the memory stage
//   op_accept, busy, stall      front-end handshake / stall
//   mem_req/push/pop/wdata      registered beat request to the memory stage
//   pc_load, pc_value           one-cycle PC load
//   flags_load, flags_value     one-cycle flags load (RTI only)
//   int_ack                     hardware interrupt taken this cycle
module stack_sequencer #(
  parameter int unsigned     PC_W    = 32,
  parameter int unsigned     DATA_W  = 16,
  parameter logic [PC_W-1:0] INT_VEC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [6:0]        opcode,
  input  logic [PC_W-1:0]   pc_cur,
  input  logic [PC_W-1:0]   pc_ret,
  input  logic [PC_W-1:0]   target,
  input  logic [2:0]        flags_in,
  input  logic              int_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              op_accept,
  output logic              busy,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_push,
  output logic              mem_pop,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_value,
  output logic              flags_load,
  output logic [2:0]        flags_value,
  output logic              int_ack
);

  localparam int unsigned HiW = PC_W - DATA_W;

  typedef enum logic [1:0] {StIdle, StBeat, StLoad} state_e;
  // Encoding matches opcode[3:2] of the 111xx stack opcodes.
  typedef enum logic [1:0] {OpCall, OpRet, OpInt, OpRti} op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [1:0]        beat_q, beat_d;
  logic [PC_W-1:0]   pc_q, pc_d;      // pushed PC, or PC assembled from pops
  logic [PC_W-1:0]   tgt_q, tgt_d;
  logic [2:0]        flags_q, flags_d;
  logic              int_en_q, int_en_d;
  logic              req_q, req_d;
  logic              push_q, push_d;
  logic              pop_q, pop_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              int_take;
  logic              is_stack;
  op_e               dec_op;
  logic [1:0]        last_idx;
  logic              unused_opcode;

  assign unused_opcode = ^opcode[1:0];

  // Push order: PC high half, PC low half, then zero-extended flags.
  function automatic logic [DATA_W-1:0] push_word(input logic [1:0]      idx,
                                                  input logic [PC_W-1:0] pc,
                                                  input logic [2:0]      fl);
    case (idx)
      2'd0:    push_word = DATA_W'(pc[PC_W-1:DATA_W]);
      2'd1:    push_word = pc[DATA_W-1:0];
      default: push_word = DATA_W'(fl);
    endcase
  endfunction

  function automatic logic op_is_push(input op_e op);
    op_is_push = (op == OpCall) || (op == OpInt);
  endfunction

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    beat_d      = beat_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    flags_d     = flags_q;
    int_en_d    = int_en_q;
    req_d       = req_q;
    push_d      = push_q;
    pop_d       = pop_q;
    wdata_d     = wdata_q;
    int_take    = 1'b0;
    op_accept   = 1'b0;
    pc_load     = 1'b0;
    pc_value    = '0;
    flags_load  = 1'b0;
    flags_value = '0;

    is_stack = (opcode[6:4] == 3'b111);
    dec_op   = op_e'(opcode[3:2]);
    last_idx = ((op_q == OpCall) || (op_q == OpRet)) ? 2'd1 : 2'd2;

    unique case (state_q)
      StIdle: begin
        // Hardware entry beats the opcode in decode; that opcode re-executes after RTI.
        int_take  = int_req & int_en_q;
        op_accept = ~int_take & op_valid & is_stack;
        if (int_take) begin
          op_d     = OpInt;
          pc_d     = pc_cur;
          flags_d  = flags_in;
          int_en_d = 1'b0;
        end else if (op_accept) begin
          op_d    = dec_op;
          pc_d    = pc_ret;
          tgt_d   = target;
          flags_d = flags_in;
          if (dec_op == OpInt) begin
            int_en_d = 1'b0;
          end
        end
        if (int_take || op_accept) begin
          state_d = StBeat;
          beat_d  = 2'd0;
          req_d   = 1'b1;
          push_d  = op_is_push(op_d);
          pop_d   = ~push_d;
          wdata_d = push_d ? push_word(2'd0, pc_d, flags_d) : '0;
        end
      end

      StBeat: begin
        if (req_q && mem_ack) begin
          if (pop_q) begin
            // RET pops lo, hi; RTI pops flags, lo, hi.
            if ((op_q == OpRti) && (beat_q == 2'd0)) begin
              flags_d = mem_rdata[2:0];
            end else if (beat_q == last_idx) begin
              pc_d[PC_W-1:DATA_W] = HiW'(mem_rdata);
            end else begin
              pc_d[DATA_W-1:0] = mem_rdata;
            end
          end
          if (beat_q == last_idx) begin
            state_d = StLoad;
            req_d   = 1'b0;
            push_d  = 1'b0;
            pop_d   = 1'b0;
            wdata_d = '0;
          end else begin
            // Back-to-back: req stays high with the next beat's data.
            beat_d  = beat_q + 2'd1;
            wdata_d = push_q ? push_word(beat_d, pc_q, flags_q) : '0;
          end
        end
      end

      StLoad: begin
        pc_load = 1'b1;
        case (op_q)
          OpCall:  pc_value = tgt_q;
          OpInt:   pc_value = INT_VEC;
          default: pc_value = pc_q;
        endcase
        if (op_q == OpRti) begin
          flags_load  = 1'b1;
          flags_value = flags_q;
          int_en_d    = 1'b1;
        end
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OpCall;
      beat_q   <= 2'd0;
      pc_q     <= '0;
      tgt_q    <= '0;
      flags_q  <= 3'd0;
      int_en_q <= 1'b1;
      req_q    <= 1'b0;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      beat_q   <= beat_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      flags_q  <= flags_d;
      int_en_q <= int_en_d;
      req_q    <= req_d;
      push_q   <= push_d;
      pop_q    <= pop_d;
      wdata_q  <= wdata_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign stall     = busy | op_accept | int_take;
  assign int_ack   = int_take;
  assign mem_req   = req_q;
  assign mem_push  = push_q;
  assign mem_pop   = pop_q;
  assign mem_wdata = wdata_q;

endmodule
